// File: rtl/alu_cmd_seq_if.sv
// Bundle of command, ALU-drive and result signals for alu_cmd_seq.
// slave = sequencer side, master = upstream/ALU/consumer side.
interface alu_cmd_seq_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic         cmd_chain;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;

    logic [W-1:0] alu_num1;
    logic [W-1:0] alu_num2;
    logic [2:0]   alu_in_selector;
    logic [6:0]   alu_out_selector;
    logic [W-1:0] alu_result;
    logic         alu_overflow;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_ovf;
    logic         res_illegal;

    logic         clr_halt;
    logic         halted;

    modport slave (
        input  cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b,
        input  alu_result, alu_overflow,
        input  res_ready, clr_halt,
        output cmd_ready,
        output alu_num1, alu_num2, alu_in_selector, alu_out_selector,
        output res_valid, res_data, res_ovf, res_illegal, halted
    );

    modport master (
        output cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b,
        output alu_result, alu_overflow,
        output res_ready, clr_halt,
        input  cmd_ready,
        input  alu_num1, alu_num2, alu_in_selector, alu_out_selector,
        input  res_valid, res_data, res_ovf, res_illegal, halted
    );
endinterface

// File: rtl/alu_cmd_seq.sv
// Command FIFO + IDLE/ISSUE/CAPTURE/HOLD sequencer driving an external 8-bit ALU.
// Optional feature macro: ALU_SEQ_OVF_HALT_EN (sticky halt on captured multiply overflow).
module alu_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_cmd_seq_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 4 + 2 * W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] OP_ILLEGAL = 3'd7;
    localparam logic [2:0] IN_RESET   = 3'b001;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_PERSIST = 3'b100;
    localparam logic [6:0] OUT_SUB    = 7'b0000010;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        HOLD
    } state_t;

    function automatic logic [6:0] op_onehot(input logic [2:0] op);
        logic [6:0] sel;
        case (op)
            3'd0:    sel = 7'b1000000;
            3'd1:    sel = 7'b0100000;
            3'd2:    sel = 7'b0010000;
            3'd3:    sel = 7'b0001000;
            3'd4:    sel = 7'b0000100;
            3'd5:    sel = 7'b0000010;
            3'd6:    sel = 7'b0000001;
            default: sel = 7'b0000000;
        endcase
        return sel;
    endfunction

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    logic [2:0]    r_op;
    logic [W-1:0]  r_num1;
    logic [W-1:0]  r_num2;
    logic [6:0]    r_out_sel;
    logic [W-1:0]  r_last_result;
    logic          r_res_valid;
    logic [W-1:0]  r_res_data;
    logic          r_res_ovf;
    logic          r_res_illegal;

    logic          w_not_full;
    logic          w_push;
    logic          w_pop;
    logic          w_halted;
    logic [EW-1:0] w_head;
    logic [2:0]    w_head_op;
    logic          w_head_chain;
    logic [W-1:0]  w_head_a;
    logic [W-1:0]  w_head_b;
    logic [2:0]    w_in_sel;

    assign w_not_full = (r_count != DEPTH_C);
    assign w_push     = bus.cmd_valid && w_not_full;
    assign w_pop      = (r_state == IDLE) && (r_count != '0) && !w_halted;

    assign w_head = r_mem[r_rd_ptr];
    assign {w_head_op, w_head_chain, w_head_a, w_head_b} = w_head;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.cmd_op, bus.cmd_chain, bus.cmd_a, bus.cmd_b};
        end
    end

    // Reset has priority over push, so a command offered during rst is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_op          <= '0;
            r_num1        <= '0;
            r_num2        <= '0;
            r_out_sel     <= OUT_SUB;
            r_last_result <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_ovf     <= 1'b0;
            r_res_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        if (w_head_op == OP_ILLEGAL) begin
                            // Illegal ops bypass the ALU and leave last_result untouched.
                            r_res_data    <= '0;
                            r_res_ovf     <= 1'b0;
                            r_res_illegal <= 1'b1;
                            r_res_valid   <= 1'b1;
                            r_state       <= HOLD;
                        end else begin
                            r_op    <= w_head_op;
                            r_num1  <= w_head_chain ? r_last_result : w_head_a;
                            r_num2  <= w_head_b;
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_out_sel <= op_onehot(r_op);
                    r_state   <= CAPTURE;
                end
                CAPTURE: begin
                    r_res_data    <= bus.alu_result;
                    r_last_result <= bus.alu_result;
                    r_res_ovf     <= bus.alu_overflow;
                    r_res_illegal <= 1'b0;
                    r_res_valid   <= 1'b1;
                    r_state       <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_OVF_HALT_EN
    logic r_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (bus.clr_halt) begin
            r_halted <= 1'b0;
        end else if ((r_state == CAPTURE) && bus.alu_overflow) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    logic w_unused_clr_halt;

    assign w_unused_clr_halt = bus.clr_halt;
    assign w_halted          = 1'b0;
`endif

    always_comb begin
        w_in_sel = IN_PERSIST;
        if (rst) begin
            w_in_sel = IN_RESET;
        end else if (r_state == ISSUE) begin
            w_in_sel = IN_LOAD;
        end
    end

    assign bus.cmd_ready        = w_not_full;
    assign bus.alu_num1         = r_num1;
    assign bus.alu_num2         = r_num2;
    assign bus.alu_in_selector  = w_in_sel;
    assign bus.alu_out_selector = r_out_sel;
    assign bus.res_valid        = r_res_valid;
    assign bus.res_data         = r_res_data;
    assign bus.res_ovf          = r_res_ovf;
    assign bus.res_illegal      = r_res_illegal;
    assign bus.halted           = w_halted;
endmodule
